// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the count access arbiter.
package cnt_arb_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Requester indices
  localparam int unsigned REQ_WB   = 0;
  localparam int unsigned REQ_LA   = 1;
  localparam int unsigned REQ_HOST = 2;

  // Default geometry
  localparam int unsigned DEF_NREQ = 3;
  localparam int unsigned DEF_BITS = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last_grant+1 with wrap.
module rr_pick #(
  parameter  int unsigned NREQ = 3,
  localparam int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [GW-1:0]   i_last_grant,
  output logic [GW-1:0]   o_pick_c,
  output logic            o_found_c
);

  logic [GW-1:0] w_idx;

  // First requester at or after last_grant+1 (mod NREQ) wins
  always_comb begin
    o_pick_c  = '0;
    o_found_c = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = GW'((32'(i_last_grant) + k) % NREQ);
      if (!o_found_c && i_req[w_idx]) begin
        o_found_c = 1'b1;
        o_pick_c  = w_idx;
      end
    end
  end

endmodule

// File: rtl/count_access_arbiter.sv
// Round-robin shared access to the free-running count register.
module count_access_arbiter
  import cnt_arb_pkg::*;
#(
  parameter  int unsigned BITS  = DEF_BITS,
  parameter  int unsigned NREQ  = DEF_NREQ,
  localparam int unsigned GW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned BYTES = BITS / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*BYTES-1:0] req_wstrb,
  input  logic [NREQ*BITS-1:0]  req_wdata,
  input  logic                  count_en,
  output logic [NREQ-1:0]       req_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic [BITS-1:0]       count
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     r_last;
  logic [NREQ-1:0]   r_ready;
  logic [BITS-1:0]   r_rdata;
  logic [BITS-1:0]   r_count;
  logic              r_busy;

  logic [GW-1:0]     w_pick;
  logic              w_found;
  logic              w_we_g;
  logic [BYTES-1:0]  w_wstrb_g;
  logic [BITS-1:0]   w_wdata_g;
  logic [BITS-1:0]   w_merged;
  logic [NREQ-1:0]   w_ready_hot;
  logic              w_wr_commit;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req        (req_valid),
    .i_last_grant (r_last),
    .o_pick_c     (w_pick),
    .o_found_c    (w_found)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, granted requester's payload, strobe merge and commit decision
  always_comb begin
    w_state_nxt = r_state;
    w_we_g      = 1'b0;
    w_wstrb_g   = '0;
    w_wdata_g   = '0;
    w_ready_hot = '0;
    w_merged    = r_count;
    w_wr_commit = 1'b0;

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == r_grant) begin
        w_we_g         = req_we[i];
        w_wstrb_g      = req_wstrb[i*BYTES +: BYTES];
        w_wdata_g      = req_wdata[i*BITS +: BITS];
        w_ready_hot[i] = 1'b1;
      end
    end

    for (int unsigned b = 0; b < BYTES; b++) begin
      if (w_wstrb_g[b]) w_merged[b*8 +: 8] = w_wdata_g[b*8 +: 8];
    end

    case (r_state)
      ST_IDLE:    if (w_found) w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        w_wr_commit = w_we_g && (|w_wstrb_g);
        w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, ready pulse, read capture and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_last  <= GW'(NREQ - 1);
      r_ready <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_ready <= '0;
          if (w_found) r_grant <= w_pick;
        end
        ST_ACCESS: begin
          r_rdata <= r_count;
          r_ready <= w_ready_hot;
          r_last  <= r_grant;
        end
        default: r_ready <= '0;
      endcase
    end
  end

  // Count register: a committed write overrides the increment
  always_ff @(posedge clk) begin
    if (reset)            r_count <= '0;
    else if (w_wr_commit) r_count <= w_merged;
    else if (count_en)    r_count <= r_count + BITS'(1);
  end

  assign req_ready = r_ready;
  assign rsp_rdata = r_rdata;
  assign grant_id  = r_grant;
  assign busy      = r_busy;
  assign count     = r_count;

endmodule

// File: tb/tb_count_access_arbiter.sv
// Directed self-checking bench for count_access_arbiter.
module tb_count_access_arbiter;

  localparam int unsigned BITS  = 32;
  localparam int unsigned NREQ  = 3;
  localparam int unsigned BYTES = BITS / 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*BYTES-1:0] req_wstrb;
  logic [NREQ*BITS-1:0]  req_wdata;
  logic                  count_en;
  logic [NREQ-1:0]       req_ready;
  logic [BITS-1:0]       rsp_rdata;
  logic [1:0]            grant_id;
  logic                  busy;
  logic [BITS-1:0]       count;

  int checks;
  int errors;
  int cyc;
  int npulse;
  int last_pulse_cyc;
  logic [1:0] exp_g;

  count_access_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_wstrb (req_wstrb),
    .req_wdata (req_wdata),
    .count_en  (count_en),
    .req_ready (req_ready),
    .rsp_rdata (rsp_rdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access by a single requester; checks grant, ready, rdata and count after commit
  task automatic do_access(input int idx, input logic we, input logic [3:0] strb,
                           input logic [31:0] data, input logic [31:0] exp_rdata,
                           input logic [31:0] exp_count);
    req_we            = '0;
    req_wstrb         = '0;
    req_wdata         = '0;
    req_we[idx]       = we;
    req_wstrb[idx*4 +: 4]   = strb;
    req_wdata[idx*32 +: 32] = data;
    req_valid         = '0;
    req_valid[idx]    = 1'b1;
    tick();
    check("acc_grant", 32'(grant_id), 32'(idx));
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_ready_pre", 32'(req_ready), 32'd0);
    tick();
    check("acc_ready", 32'(req_ready), 32'(1 << idx));
    check("acc_rdata", rsp_rdata, exp_rdata);
    check("acc_count", count, exp_count);
    req_valid = '0;
    req_we    = '0;
    req_wstrb = '0;
    tick();
    check("acc_ready_drop", 32'(req_ready), 32'd0);
    check("acc_busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_wstrb = '0;
    req_wdata = '0;
    count_en  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst_count", count, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);

    // Free-running count
    count_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    count_en = 1'b0;
    check("cnt10", count, 32'd10);
    check("cnt10_ready", 32'(req_ready), 32'd0);
    check("cnt10_busy", 32'(busy), 32'd0);

    // Requester 0 full write while counting: captured read is 5
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("pre_wr_count", count, 32'd4);
    req_valid = 3'b001;
    req_we    = 3'b001;
    req_wstrb = 12'h00F;
    req_wdata = {64'd0, 32'hDEADBEEF};
    tick();
    check("wr0_grant", 32'(grant_id), 32'd0);
    check("wr0_busy", 32'(busy), 32'd1);
    check("wr0_count_at_access", count, 32'd5);
    tick();
    check("wr0_rdata", rsp_rdata, 32'd5);
    check("wr0_ready", 32'(req_ready), 32'b001);
    check("wr0_count", count, 32'hDEADBEEF);
    req_valid = '0;
    req_we    = '0;
    req_wstrb = '0;
    tick();
    check("wr0_inc", count, 32'hDEADBEF0);
    check("wr0_ready_drop", 32'(req_ready), 32'd0);
    count_en = 1'b0;

    // Host full write, then LA byte-1 write with increment disabled
    do_access(2, 1'b1, 4'hF, 32'h11223344, 32'hDEADBEF0, 32'h11223344);
    do_access(1, 1'b1, 4'h2, 32'h0000AB00, 32'h11223344, 32'h1122AB44);

    // Write with no strobes leaves count alone (and would not block increment)
    do_access(2, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h1122AB44, 32'h1122AB44);

    // All three requesters held valid: grants rotate 0,1,2,0 three cycles apart
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 3'b111;
    npulse = 0;
    last_pulse_cyc = 0;
    for (cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (req_ready != '0) begin
        exp_g = 2'(npulse % 3);
        check("rr_ready", 32'(req_ready), 32'(1 << exp_g));
        check("rr_grant", 32'(grant_id), 32'(exp_g));
        check("rr_rdata", rsp_rdata, 32'd0);
        if (npulse > 0) check("rr_spacing", 32'(cyc - last_pulse_cyc), 32'd3);
        else            check("rr_first_cyc", 32'(cyc), 32'd2);
        last_pulse_cyc = cyc;
        npulse++;
      end
    end
    req_valid = '0;
    check("rr_npulse", 32'(npulse), 32'd4);
    tick();

    // Wrap: write all ones, next increment rolls to 0
    count_en = 1'b1;
    do_access(1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);
    check("wrap_count", count, 32'd0);

    // Reset mid-access aborts the write and the ready pulse
    tick();
    tick();
    tick();
    count_en = 1'b0;
    check("pre_abort_count", count, 32'd3);
    req_valid = 3'b100;
    req_we    = 3'b100;
    req_wstrb = 12'hF00;
    req_wdata = {32'h12345678, 64'd0};
    tick();
    check("abort_grant", 32'(grant_id), 32'd2);
    check("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_count", count, 32'd0);
    check("abort_busy_rst", 32'(busy), 32'd0);
    req_valid = 3'b111;
    req_we    = '0;
    req_wstrb = '0;
    tick();
    check("post_abort_grant", 32'(grant_id), 32'd0);
    tick();
    check("post_abort_ready", 32'(req_ready), 32'b001);
    check("post_abort_count", count, 32'd0);
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_access_arbiter.md
# count_access_arbiter

Sequences and shares the 32-bit count register among three requesters: the Wishbone slave port, the logic-analyzer probe path and the USB-UART host bridge. Replaces ad-hoc fixed-priority muxing with round-robin grants and a fixed three-state access sequence. Owns the count register, its free-running increment and the per-requester ready handshake. Sits between the user-project bus adapters and the count/IO outputs.

## Interface
- BITS, 32, count/data width; must be a multiple of 8
- NREQ, 3, number of requesters; index 0 = Wishbone, 1 = LA, 2 = host
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester access request; held high until its req_ready pulse
- req_we  in  NREQ  per-requester write enable (0 = read only)
- req_wstrb  in  NREQ*BITS/8  byte strobes; requester i uses slice [i*BITS/8 +: BITS/8]
- req_wdata  in  NREQ*BITS  write data; requester i uses slice [i*BITS +: BITS]
- count_en  in  1  enables the free-running increment
- req_ready  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- rsp_rdata  out  BITS  count value captured at the access; shared by all requesters, valid while req_ready is high
- grant_id  out  clog2(NREQ)  index of the current or most recent grant
- busy  out  1  high in ACCESS and RELEASE
- count  out  BITS  current count register

## Operation
- States: IDLE, ACCESS, RELEASE.
- IDLE: if any req_valid is high, select a winner by round-robin and latch it into grant_id. Search starts at (last_grant+1) mod NREQ and wraps. Go to ACCESS. If no request, stay in IDLE.
- ACCESS (always one cycle):
  - rsp_rdata <= count (value before this edge's update).
  - If req_we and any strobe are set for the winner, load the strobed bytes from wdata, keep the unstrobed bytes, and suppress the increment this cycle.
  - Set req_ready[grant] <= 1, last_grant <= grant, go to RELEASE.
- RELEASE: req_ready <= 0, go to IDLE. This cycle gives the requester time to drop req_valid before the next arbitration.
- Increment: if count_en is high and no write commits at that edge, count <= count + 1 modulo 2^BITS (0xFFFFFFFF wraps to 0). Applies in every state.
- A read-only access, or a write with all strobes zero, does not suppress the increment.
- req_valid dropped while in ACCESS: the access was committed at grant and still completes, including the ready pulse.
- req_valid from a non-granted requester is ignored until the next IDLE.
- Only a single requester is ever in flight; requesters never see back-pressure other than a delayed ready.

## Timing
- Reset values: state IDLE, count 0, rsp_rdata 0, req_ready 0, grant_id 0, busy 0, last_grant NREQ-1 (so requester 0 has first priority).
- Reset mid-access aborts the access: no write commits and no ready pulse is issued.
- Latency: req_valid sampled in IDLE at edge N -> write/read commits at edge N+1 -> req_ready high during cycle N+1..N+2.
- Minimum spacing between grants is 3 cycles; throughput is one access per 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,2,0,… and each requester waits at most 3 accesses (9 cycles).

## Structure
- Shared package cnt_arb_pkg:
  - state enum (IDLE, ACCESS, RELEASE)
  - requester index constants REQ_WB=0, REQ_LA=1, REQ_HOST=2
  - default NREQ/BITS constants
- Sub-module rr_pick: purely combinational round-robin picker. Inputs are the request vector and last_grant; outputs are the winner index and a found flag. Reusable by the UART bridge for command arbitration.
- Top-level module holds the FSM, the count register, the strobe merge and the ready/rdata registers.

## Test plan
- Reset, count_en=1 for 10 cycles -> count=10; req_ready=0; busy=0.
- Requester 0 writes 0xDEADBEEF with strobe 0xF while count=5 -> rsp_rdata=5, req_ready=001 for one cycle, count=0xDEADBEEF, then 0xDEADBEF0 on the next edge.
- Requester 1 writes with strobe 0x2 and data 0x0000AB00 while count=0x11223344, count_en=0 -> count=0x1122AB44.
- All three requesters held valid (read-only) -> grant_id sequence 0,1,2,0 and ready pulses exactly 3 cycles apart.
- Write 0xFFFFFFFF (strobe 0xF), then count_en=1 -> count wraps to 0 one edge after the write.
- Reset asserted in ACCESS with a pending write -> no ready pulse, count=0; the next grant goes to requester 0.
